// File: rtl/cia_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cia_bus_sequencer
// Description : FPGA-side bus master for cia_core. Generates a free-running
//               PHI2 clock and a power-on /RES pulse, arbitrates two host
//               requesters round-robin and runs at most one CIA register
//               access per PHI2 cycle.
// Ports       : clk, rst        - system clock, async active-high reset
//               req/we          - per-requester request and write flag
//               addr0/1,wdata0/1- per-requester address and write data
//               ack, rdata      - one-clk completion pulse, read data
//               cia_data_i      - data returned by cia_core
//               phi2,res_n,cs_n,r_w_n,cia_addr,cia_data_o - cia_core bus
// Revision    : 1.0 - initial release
// ============================================================================
module cia_bus_sequencer #(
    parameter int PHI2_LO  = 4,
    parameter int PHI2_HI  = 4,
    parameter int RES_PHI2 = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] we,
    input  logic [3:0] addr0,
    input  logic [3:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic [1:0] ack,
    output logic [7:0] rdata,
    input  logic [7:0] cia_data_i,
    output logic       phi2,
    output logic       res_n,
    output logic       cs_n,
    output logic       r_w_n,
    output logic [3:0] cia_addr,
    output logic [7:0] cia_data_o
);

    localparam int PERIOD = PHI2_LO + PHI2_HI;
    localparam int CW     = $clog2(PERIOD);
    localparam int RW     = $clog2(RES_PHI2 + 1);

    // Arbitration needs cnt==1 to be inside the low phase and the bus needs
    // at least one cs_n-low low cycle plus a high phase before the wrap.
    if (PHI2_LO < 3 || PHI2_HI < 2 || RES_PHI2 < 1) begin : g_param_check
        $error("cia_bus_sequencer: PHI2_LO must be >= 3, PHI2_HI >= 2, RES_PHI2 >= 1");
    end

    typedef enum logic [0:0] {
        ST_FREE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_res_cnt;
    logic            r_last_grant;
    logic            r_grant;

    logic            w_wrap;
    logic [CW-1:0]   w_cnt_next;
    logic            w_arb;
    logic            w_pick;
    logic            w_sel_we;
    logic [3:0]      w_sel_addr;
    logic [7:0]      w_sel_wdata;

    assign w_wrap     = (r_cnt == CW'(PERIOD - 1));
    assign w_cnt_next = w_wrap ? '0 : r_cnt + CW'(1);

    // Sample point is the end of cnt==1: late-rising requests wait a cycle,
    // and a request dropped on the ack edge is never seen twice.
    assign w_arb = (r_cnt == CW'(1)) && (r_state == ST_FREE) && res_n && (|req);

    // Round-robin: on contention the port that did not win last time goes.
    assign w_pick      = (req == 2'b11) ? ~r_last_grant : req[1];
    assign w_sel_we    = w_pick ? we[1]  : we[0];
    assign w_sel_addr  = w_pick ? addr1  : addr0;
    assign w_sel_wdata = w_pick ? wdata1 : wdata0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FREE;
            r_cnt        <= '0;
            r_res_cnt    <= '0;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            phi2         <= 1'b0;
            res_n        <= 1'b0;
            cs_n         <= 1'b1;
            r_w_n        <= 1'b1;
            cia_addr     <= '0;
            cia_data_o   <= '0;
            ack          <= '0;
            rdata        <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            // Registered from the next count so phi2 lines up with cnt.
            phi2  <= (w_cnt_next >= CW'(PHI2_LO));
            ack   <= '0;

            if (w_wrap && (r_res_cnt != RW'(RES_PHI2))) begin
                r_res_cnt <= r_res_cnt + RW'(1);
                if (r_res_cnt == RW'(RES_PHI2 - 1)) begin
                    res_n <= 1'b1;
                end
            end

            case (r_state)
                ST_FREE: begin
                    if (w_arb) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        cia_addr     <= w_sel_addr;
                        cia_data_o   <= w_sel_wdata;
                        r_w_n        <= ~w_sel_we;
                        cs_n         <= 1'b0;
                        r_state      <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_wrap) begin
                        // cia_data_i here is the value present in the last
                        // high cycle, i.e. at the PHI2 falling edge.
                        if (r_w_n) begin
                            rdata <= cia_data_i;
                        end
                        ack     <= r_grant ? 2'b10 : 2'b01;
                        cs_n    <= 1'b1;
                        r_w_n   <= 1'b1;
                        r_state <= ST_FREE;
                    end
                end
                default: r_state <= ST_FREE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cia_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cia_bus_sequencer
// Description : Self-checking bench for cia_bus_sequencer. Transactions are
//               predicted at PHI2-cycle granularity and pushed into a
//               scoreboard queue; a monitor pops them when ack appears and
//               checks the bus during each access window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cia_bus_sequencer;

    localparam int PER      = 8;      // PHI2 period in clk with defaults
    localparam int RES_CLKS = 10 * PER;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic [1:0] req, we;
    logic [1:0] ack;
    logic [7:0] rdata;
    logic [7:0] cia_data_i;
    logic       phi2, res_n, cs_n, r_w_n;
    logic [3:0] cia_addr;
    logic [7:0] cia_data_o;

    assign req = {req1, req0};
    assign we  = {we1, we0};

    cia_bus_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .ack        (ack),
        .rdata      (rdata),
        .cia_data_i (cia_data_i),
        .phi2       (phi2),
        .res_n      (res_n),
        .cs_n       (cs_n),
        .r_w_n      (r_w_n),
        .cia_addr   (cia_addr),
        .cia_data_o (cia_data_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // clk edges since reset release; the phase inside PHI2 is pcount % PER.
    int pcount;
    always @(posedge clk or posedge rst) begin
        if (rst) pcount <= 0;
        else     pcount <= pcount + 1;
    end

    // Simple CIA register file on the bus side; writes land at PHI2 fall.
    logic [7:0] cia_mem   [16];
    logic [7:0] model_mem [16];
    assign cia_data_i = cia_mem[cia_addr];
    always @(posedge clk) begin
        if (!rst && !cs_n && !r_w_n && (pcount % PER) == PER - 1)
            cia_mem[cia_addr] <= cia_data_o;
    end

    typedef struct {
        int         port;
        bit         wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         cyc;
    } txn_t;

    txn_t sbq[$];
    int   last_grant = 1;
    logic [7:0] exp_rdata = '0;

    function automatic int pick(input logic [1:0] r, input int lg);
        if (r == 2'b11) return 1 - lg;
        return r[1] ? 1 : 0;
    endfunction

    function automatic txn_t make_txn(input int p, input int now);
        txn_t t;
        t.port  = p;
        t.wr    = (p == 1) ? we1 : we0;
        t.addr  = (p == 1) ? addr1 : addr0;
        t.wdata = (p == 1) ? wdata1 : wdata0;
        t.rdata = model_mem[t.addr];
        t.cyc   = now + PER - 1;  // ack shows in the next cnt==0 cycle
        return t;
    endfunction

    // Reference model: one grant decision per PHI2 cycle, once /RES is over.
    always @(negedge clk) begin
        if (rst) begin
            last_grant <= 1;
        end else if ((pcount % PER) == 1 && pcount >= RES_CLKS && req != 2'b00) begin
            sbq.push_back(make_txn(pick(req, last_grant), pcount));
            last_grant <= pick(req, last_grant);
            if (((pick(req, last_grant) == 1) ? we1 : we0) == 1'b1)
                model_mem[(pick(req, last_grant) == 1) ? addr1 : addr0] <=
                    (pick(req, last_grant) == 1) ? wdata1 : wdata0;
        end
    end

    // Monitor: pops the scoreboard on ack and checks the bus every cycle.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            exp_rdata <= '0;
        end else begin
            chk("phi2", phi2, ((pcount % PER) >= 4));
            chk("res_n", res_n, (pcount >= RES_CLKS));
            if (ack != 2'b00) begin
                if (ack == 2'b11) begin
                    chk("ack_exclusive", ack, 2'b01);
                end else if (sbq.size() == 0) begin
                    chk("ack_spurious", ack, 2'b00);
                end else begin
                    chk("ack_port", ack, (sbq[0].port == 1) ? 2'b10 : 2'b01);
                    chk("ack_time", pcount, sbq[0].cyc);
                    chk("rdata", rdata, sbq[0].wr ? exp_rdata : sbq[0].rdata);
                    if (!sbq[0].wr) exp_rdata <= sbq[0].rdata;
                    void'(sbq.pop_front());
                end
            end else if (sbq.size() != 0 && pcount >= sbq[0].cyc) begin
                chk("ack_missing", ack, (sbq[0].port == 1) ? 2'b10 : 2'b01);
                void'(sbq.pop_front());
            end
            if ((pcount % PER) >= 2 && sbq.size() != 0) begin
                chk("cs_n_active", cs_n, 1'b0);
                chk("r_w_n", r_w_n, !sbq[0].wr);
                chk("cia_addr", cia_addr, sbq[0].addr);
                if (sbq[0].wr) chk("cia_data_o", cia_data_o, sbq[0].wdata);
            end else begin
                chk("cs_n_idle", cs_n, 1'b1);
            end
        end
    end

    task automatic access(input int p, input bit w, input logic [3:0] a, input logic [7:0] d);
        logic got;
        if (p == 1) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else        begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            got = ack[p];
        end
        chk("ack_arrived", got, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            cia_mem[i]   = 8'($urandom);
            model_mem[i] = cia_mem[i];
        end
        cia_mem[13]   = 8'h81;
        model_mem[13] = 8'h81;

        rst = 1'b1;
        idle(3);
        chk("rst_phi2", phi2, 1'b0);
        chk("rst_res_n", res_n, 1'b0);
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_r_w_n", r_w_n, 1'b1);
        chk("rst_cia_addr", cia_addr, 4'h0);
        chk("rst_cia_data_o", cia_data_o, 8'h00);
        chk("rst_ack", ack, 2'b00);
        chk("rst_rdata", rdata, 8'h00);
        rst = 1'b0;

        // Request raised during the /RES pulse, then single read, readback.
        idle(2 * PER);
        access(0, 1'b1, 4'h4, 8'h25);
        req0 = 1'b0;
        access(1, 1'b0, 4'hD, 8'h00);
        req1 = 1'b0;
        access(0, 1'b0, 4'h4, 8'h00);
        req0 = 1'b0;
        idle(5);

        // Contention: both ports hold req for three accesses each.
        fork
            begin
                for (int i = 0; i < 3; i++) access(0, 1'b1, 4'(i), 8'($urandom));
                req0 = 1'b0;
            end
            begin
                for (int i = 0; i < 3; i++) access(1, 1'b0, 4'(i + 8), 8'h00);
                req1 = 1'b0;
            end
        join
        idle(3);

        // Randomised traffic from both ports.
        fork
            begin
                for (int i = 0; i < 15; i++) begin
                    idle($urandom_range(0, 10));
                    access(0, 1'($urandom), 4'($urandom), 8'($urandom));
                    req0 = 1'b0;
                end
            end
            begin
                for (int i = 0; i < 15; i++) begin
                    idle($urandom_range(0, 10));
                    access(1, 1'($urandom), 4'($urandom), 8'($urandom));
                    req1 = 1'b0;
                end
            end
        join
        idle(PER);

        // Reset in the middle of an active write (cnt==5, phi2 high).
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h2; wdata0 = 8'h5A;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if ((pcount % PER) == 5 && sbq.size() != 0) break;
        end
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_cs_n", cs_n, 1'b1);
        chk("midrst_ack", ack, 2'b00);
        chk("midrst_phi2", phi2, 1'b0);
        chk("midrst_res_n", res_n, 1'b0);
        req0 = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(RES_CLKS + 20);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
